mux_sel_arbiter: RTL

Two-requester round-robin arbiter that generates the registered `sel` control for the 2-to-1 mux stage directly downstream. Requester 0 owns mux input `in0` and requester 1 owns `in1`. The block grants one requester at a time and holds each grant for a minimum number of cycles, so the mux output never glitches between sources. It also exports one-hot grants and a wrapping grant counter for debug.

---
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-requester round-robin arbiter driving a registered 2:1 mux select with minimum grant hold
//
// Parameters:
//   HOLD_CYCLES - minimum grant length in clock cycles (>= 1)
//   CNT_W       - hold counter width, 2**CNT_W >= HOLD_CYCLES
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req0      - level request from source 0 (mux in0)
//   req1      - level request from source 1 (mux in1)
//   sel       - registered mux select, 0 = in0, 1 = in1
//   gnt0      - registered grant to source 0
//   gnt1      - registered grant to source 1
//   busy      - either grant active
//   grant_cnt - wrapping count of grant entries
module mux_sel_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic       sel,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic [7:0] grant_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [7:0]       grant_cnt_q, grant_cnt_d;
    logic             hold_done;
    logic             enter;
    logic             enter_src;

    assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        grant_cnt_d = grant_cnt_q;
        enter       = 1'b0;
        enter_src   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    enter     = 1'b1;
                    // a tie goes to whichever source was not served last
                    enter_src = (req0 && req1) ? ~last_q : req1;
                end
            end
            GRANT0: begin
                if (!hold_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (req1) begin
                    // the waiting source outranks our own request once the hold expires
                    enter     = 1'b1;
                    enter_src = 1'b1;
                end else if (!req0) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                if (!hold_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (req0) begin
                    enter     = 1'b1;
                    enter_src = 1'b0;
                end else if (!req1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // every grant entry, including a direct switch, restarts the hold and bumps the counter
        if (enter) begin
            state_d     = enter_src ? GRANT1 : GRANT0;
            cnt_d       = '0;
            sel_d       = enter_src;
            last_d      = enter_src;
            grant_cnt_d = grant_cnt_q + 8'd1;
        end
    end

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign busy      = gnt0 | gnt1;
    assign sel       = sel_q;
    assign grant_cnt = grant_cnt_q;

endmodule
